// File: rtl/dmem_result_checker.sv
// In-order result checker for the data-memory output stream: compares strobed words
// against a preloaded expected table and reports pass count, first mismatch and timeout.
module dmem_result_checker #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          Reset_L,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [31:0]   cfg_data,
    input  logic [IW:0]   cfg_num,
    input  logic          start,
    input  logic          obs_valid,
    input  logic [31:0]   obs_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [7:0]    passed_cnt,
    output logic          fail_valid,
    output logic [IW-1:0] fail_idx,
    output logic [31:0]   fail_data
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW:0]   DepthW  = (IW+1)'(DEPTH);
    localparam logic [CW-1:0] IdleMax = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [IW:0]   num_q;
    logic [CW-1:0] idle_q;

    logic [31:0]   exp_mem [DEPTH];

    logic [IW:0]   num_clamped;
    logic          match;
    logic          last;
    logic [7:0]    passed_inc;
    logic [7:0]    passed_nxt;
    logic          all_passed;

    // Table has no reset; writes are locked out while a run is reading it.
    always_ff @(posedge CLK) begin
        if (cfg_we && (state_q != StRun)) begin
            exp_mem[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        num_clamped = (cfg_num > DepthW) ? DepthW : cfg_num;
        match       = (obs_data == exp_mem[idx_q]);
        last        = ({1'b0, idx_q} == (num_q - (IW+1)'(1)));
        passed_inc  = (passed_cnt == 8'hff) ? passed_cnt : passed_cnt + 8'd1;
        passed_nxt  = match ? passed_inc : passed_cnt;
        all_passed  = (16'(passed_nxt) == 16'(num_q));
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            num_q      <= '0;
            idle_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            passed_cnt <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_data  <= '0;
        end else if (start) begin
            // Restart from any state; a coincident result is dropped.
            idx_q      <= '0;
            num_q      <= num_clamped;
            idle_q     <= '0;
            timeout    <= 1'b0;
            passed_cnt <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_data  <= '0;
            if (num_clamped == '0) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b1;
            end else begin
                state_q <= StRun;
                busy    <= 1'b1;
                done    <= 1'b0;
                pass    <= 1'b0;
            end
        end else if (state_q == StRun) begin
            if (obs_valid) begin
                passed_cnt <= passed_nxt;
                idle_q     <= '0;
                if (!match && !fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_idx   <= idx_q;
                    fail_data  <= obs_data;
                end
                if (last) begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= all_passed;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else if (idle_q == IdleMax) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_result_checker.sv
// Bench for dmem_result_checker: per-result passed_cnt scoreboard plus end-of-run checks.
module tb_dmem_result_checker;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned IW      = 4;
    localparam int unsigned TIMEOUT = 64;

    logic          CLK = 1'b0;
    logic          Reset_L = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [31:0]   cfg_data = '0;
    logic [IW:0]   cfg_num = '0;
    logic          start = 1'b0;
    logic          obs_valid = 1'b0;
    logic [31:0]   obs_data = '0;
    logic          busy, done, pass, timeout, fail_valid;
    logic [7:0]    passed_cnt;
    logic [IW-1:0] fail_idx;
    logic [31:0]   fail_data;

    int total = 0;
    int bad = 0;
    logic [7:0]  sb_q[$];
    logic [31:0] exp_model [DEPTH];
    logic [31:0] stream [12];

    dmem_result_checker #(.DEPTH(DEPTH), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start), .obs_valid(obs_valid),
        .obs_data(obs_data), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .passed_cnt(passed_cnt), .fail_valid(fail_valid), .fail_idx(fail_idx),
        .fail_data(fail_data)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_exp(input int i, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = i[IW-1:0]; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        exp_model[i] = d;
    endtask

    task automatic start_run(input int n);
        cfg_num = n[IW:0]; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        #2;
        total++;
        if ({busy, done, pass, timeout, passed_cnt, fail_valid, fail_idx, fail_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b to=%b cnt=%0d fv=%b fi=%0d fd=%h want all 0",
                     busy, done, pass, timeout, passed_cnt, fail_valid, fail_idx, fail_data);
        end
        Reset_L = 1'b1;
    endtask

    task automatic test_single();
        write_exp(0, 32'd120);
        start_run(1);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        tick(); tick();
        obs_valid = 1'b1; obs_data = 32'd120;
        tick();
        obs_valid = 1'b0;
        total++;
        if ({done, pass, busy} !== 3'b110) begin
            bad++; $display("FAIL single_end got done/pass/busy=%b want=110", {done, pass, busy});
        end
        total++;
        if (passed_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", passed_cnt); end
    endtask

    // Scoreboard: expected passed_cnt after each result is pushed when driven, popped after the edge.
    task automatic test_stream(input bit corrupt);
        logic [31:0] obs [12];
        logic [7:0]  m;
        logic [7:0]  want;
        int          first_bad;
        m = 0; first_bad = -1;
        for (int i = 0; i < 12; i++) obs[i] = stream[i];
        if (corrupt) begin obs[3] = 32'h0000b4a1; obs[7] = 32'd2; end
        start_run(12);
        for (int i = 0; i < 12; i++) begin
            obs_valid = 1'b1; obs_data = obs[i];
            if (obs[i] == exp_model[i]) m++;
            else if (first_bad < 0) first_bad = i;
            sb_q.push_back(m);
            tick();
            want = sb_q.pop_front();
            total++;
            if (passed_cnt !== want) begin
                bad++; $display("FAIL stream_cnt[%0d] got=%0d want=%0d", i, passed_cnt, want);
            end
        end
        obs_valid = 1'b0;
        total++;
        if ({done, busy, pass} !== {1'b1, 1'b0, (m == 8'd12)}) begin
            bad++; $display("FAIL stream_end got done/busy/pass=%b want=%b", {done, busy, pass},
                            {1'b1, 1'b0, (m == 8'd12)});
        end
        total++;
        if (fail_valid !== (first_bad >= 0)) begin
            bad++; $display("FAIL stream_fail_valid got=%b want=%b", fail_valid, first_bad >= 0);
        end
        if (first_bad >= 0) begin
            total++;
            if (fail_idx !== first_bad[IW-1:0] || fail_data !== obs[first_bad]) begin
                bad++; $display("FAIL stream_fail_rec got idx=%0d data=%h want idx=%0d data=%h",
                                fail_idx, fail_data, first_bad, obs[first_bad]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        write_exp(0, 32'd5);
        write_exp(1, 32'd6);
        start_run(2);
        obs_valid = 1'b1; obs_data = 32'd5;
        tick();
        obs_valid = 1'b0;
        n = 0;
        while (n < 200 && done !== 1'b1) begin
            tick();
            n++;
        end
        total++;
        if (n != TIMEOUT) begin bad++; $display("FAIL timeout_edges got=%0d want=%0d", n, TIMEOUT); end
        total++;
        if ({timeout, pass, busy, passed_cnt} !== {3'b100, 8'd1}) begin
            bad++; $display("FAIL timeout_flags got to/pass/busy=%b cnt=%0d want 100 cnt=1",
                            {timeout, pass, busy}, passed_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        start_run(3);
        obs_valid = 1'b1; obs_data = exp_model[0];
        tick();
        obs_valid = 1'b0;
        #2;
        Reset_L = 1'b0;
        #1;
        total++;
        if ({busy, done, pass, timeout, passed_cnt, fail_valid, fail_idx, fail_data} !== '0) begin
            bad++; $display("FAIL midrun_reset got busy=%b cnt=%0d fv=%b want all 0",
                            busy, passed_cnt, fail_valid);
        end
        Reset_L = 1'b1;
        write_exp(0, 32'd2);
        start_run(1);
        obs_valid = 1'b1; obs_data = 32'd2;
        tick();
        obs_valid = 1'b0;
        total++;
        if ({done, pass, passed_cnt} !== {2'b11, 8'd1}) begin
            bad++; $display("FAIL midrun_rerun got done/pass=%b cnt=%0d want 11 cnt=1",
                            {done, pass}, passed_cnt);
        end
    endtask

    task automatic test_back_to_back();
        start_run(4);
        obs_valid = 1'b1; obs_data = exp_model[0];
        tick();
        // Table write attempted while running must be ignored.
        obs_valid = 1'b0; cfg_we = 1'b1; cfg_idx = 4'd1; cfg_data = 32'h55;
        tick();
        cfg_we = 1'b0;
        obs_valid = 1'b1; obs_data = exp_model[1];
        tick();
        obs_valid = 1'b0;
        total++;
        if (passed_cnt !== 8'd2) begin bad++; $display("FAIL run_write_ignored got=%0d want=2", passed_cnt); end
        obs_valid = 1'b1; obs_data = exp_model[2];
        start_run(4);
        obs_valid = 1'b0;
        total++;
        if ({busy, done, passed_cnt, fail_valid} !== {2'b10, 8'd0, 1'b0}) begin
            bad++; $display("FAIL restart_drop got busy/done=%b cnt=%0d fv=%b want 10 cnt=0 fv=0",
                            {busy, done}, passed_cnt, fail_valid);
        end
        start_run(0);
        total++;
        if ({done, pass, busy} !== 3'b110) begin
            bad++; $display("FAIL zero_num got done/pass/busy=%b want=110", {done, pass, busy});
        end
        // Write coincident with start must be visible to the first compare.
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = 32'h33;
        exp_model[0] = 32'h33;
        start_run(1);
        cfg_we = 1'b0;
        obs_valid = 1'b1; obs_data = 32'h33;
        tick();
        obs_valid = 1'b0;
        total++;
        if ({done, pass, passed_cnt} !== {2'b11, 8'd1}) begin
            bad++; $display("FAIL write_with_start got done/pass=%b cnt=%0d want 11 cnt=1",
                            {done, pass}, passed_cnt);
        end
    endtask

    initial begin
        stream = '{32'hfeedbeef, 32'hfeedb48f, 32'hfeeeb48f, 32'h0000b4a0, 32'hddb7dde0,
                   32'h07f76df7, 32'hfff76df7, 32'h1, 32'h0, 32'h0, 32'h1, 32'hfeed4b4f};
        #1;
        test_reset();
        test_single();
        for (int i = 0; i < 12; i++) write_exp(i, stream[i]);
        test_stream(1'b0);
        test_stream(1'b1);
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
